// File: rtl/ring_router_gateway_demux_n_if.sv
// Ring gateway flit channels: one inbound ring port, local/ext/ring outbound ports.
// The slave modport is the router's view; the master modport drives it.
package ring_router_gateway_demux_n_pkg;
  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        valid;
  } dii_flit;
endpackage

interface ring_router_gateway_demux_n_if #(
  parameter int NUM_LOCAL = 2
);
  import ring_router_gateway_demux_n_pkg::*;

  dii_flit                 in_ring;
  logic                    in_ring_ready;
  dii_flit [NUM_LOCAL-1:0] out_local;
  logic    [NUM_LOCAL-1:0] out_local_ready;
  dii_flit                 out_ext;
  logic                    out_ext_ready;
  dii_flit                 out_ring;
  logic                    out_ring_ready;

  modport master (
    output in_ring,
    output out_local_ready,
    output out_ext_ready,
    output out_ring_ready,
    input  in_ring_ready,
    input  out_local,
    input  out_ext,
    input  out_ring
  );

  modport slave (
    input  in_ring,
    input  out_local_ready,
    input  out_ext_ready,
    input  out_ring_ready,
    output in_ring_ready,
    output out_local,
    output out_ext,
    output out_ring
  );
endinterface

// File: rtl/ring_router_gateway_demux_n.sv
// Ring gateway demux: routes wormhole packets to local endpoints,
// the external subnet link, or onward along the ring.
module ring_router_gateway_demux_n
  import ring_router_gateway_demux_n_pkg::*;
#(
  parameter int SUBNET_BITS  = 6,
  parameter int LOCAL_SUBNET = 0,
  parameter int NUM_LOCAL    = 2,
  parameter bit REG_OUT      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] id,
  ring_router_gateway_demux_n_if.slave bus,
  output logic [15:0] cnt_local,
  output logic [15:0] cnt_ext,
  output logic [15:0] cnt_ring
);

  localparam int TW = (NUM_LOCAL > 1) ? $clog2(NUM_LOCAL) : 1;

  typedef enum logic {
    S_IDLE,
    S_WORM
  } state_e;

  typedef enum logic [1:0] {
    C_LOCAL,
    C_EXT,
    C_RING
  } cls_e;

  state_e state_q, state_d;
  cls_e   cls_q, cls_d;
  logic [TW-1:0] tgt_q, tgt_d;

  logic          rv_q, rv_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          rlast_q, rlast_d;
  cls_e          rcls_q, rcls_d;
  logic [TW-1:0] rtgt_q, rtgt_d;

  logic [15:0] cnt_local_q, cnt_local_d;
  logic [15:0] cnt_ext_q, cnt_ext_d;
  logic [15:0] cnt_ring_q, cnt_ring_d;

  logic [15:0]            offset;
  logic [SUBNET_BITS-1:0] subnet;
  cls_e                   hdr_cls, cur_cls;
  logic [TW-1:0]          hdr_tgt, cur_tgt;
  logic                   hdr;

  logic          src_valid;
  logic [15:0]   src_data;
  logic          src_last;
  cls_e          src_cls;
  logic [TW-1:0] src_tgt;
  logic          sel_ready;
  logic          in_ready;
  logic          accept;

  dii_flit [NUM_LOCAL-1:0] loc_o;
  dii_flit                 ext_o;
  dii_flit                 ring_o;

  // Header classification; body flits reuse the latched route
  always_comb begin
    offset  = bus.in_ring.data - id;
    subnet  = bus.in_ring.data[15 -: SUBNET_BITS];
    hdr_tgt = offset[TW-1:0];
    if (offset < 16'(NUM_LOCAL)) begin
      hdr_cls = C_LOCAL;
    end else if (subnet != SUBNET_BITS'(LOCAL_SUBNET)) begin
      hdr_cls = C_EXT;
    end else begin
      hdr_cls = C_RING;
    end
    hdr     = (state_q == S_IDLE);
    cur_cls = hdr ? hdr_cls : cls_q;
    cur_tgt = hdr ? hdr_tgt : tgt_q;
  end

  always_comb begin
    if (REG_OUT) begin
      src_valid = rv_q;
      src_data  = rdata_q;
      src_last  = rlast_q;
      src_cls   = rcls_q;
      src_tgt   = rtgt_q;
    end else begin
      src_valid = bus.in_ring.valid;
      src_data  = bus.in_ring.data;
      src_last  = bus.in_ring.last;
      src_cls   = cur_cls;
      src_tgt   = cur_tgt;
    end
  end

  always_comb begin
    sel_ready = 1'b0;
    unique case (1'b1)
      (src_cls == C_LOCAL): begin
        for (int i = 0; i < NUM_LOCAL; i++) begin
          if (src_tgt == TW'(i)) begin
            sel_ready = bus.out_local_ready[i];
          end
        end
      end
      (src_cls == C_EXT):  sel_ready = bus.out_ext_ready;
      (src_cls == C_RING): sel_ready = bus.out_ring_ready;
      default:             sel_ready = 1'b0;
    endcase
  end

  // Register stage accepts when empty or draining this cycle
  always_comb begin
    if (REG_OUT) begin
      in_ready = !rst && (!rv_q || sel_ready);
    end else begin
      in_ready = !rst && sel_ready;
    end
    accept = bus.in_ring.valid && in_ready;
  end

  always_comb begin
    for (int i = 0; i < NUM_LOCAL; i++) begin
      loc_o[i].data  = src_data;
      loc_o[i].last  = src_last;
      loc_o[i].valid = src_valid && !rst &&
                       (src_cls == C_LOCAL) &&
                       (src_tgt == TW'(i));
    end
    ext_o.data   = src_data;
    ext_o.last   = src_last;
    ext_o.valid  = src_valid && !rst && (src_cls == C_EXT);
    ring_o.data  = src_data;
    ring_o.last  = src_last;
    ring_o.valid = src_valid && !rst && (src_cls == C_RING);
  end

  assign bus.out_local     = loc_o;
  assign bus.out_ext       = ext_o;
  assign bus.out_ring      = ring_o;
  assign bus.in_ring_ready = in_ready;

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    tgt_d   = tgt_q;
    if (accept) begin
      unique case (state_q)
        S_IDLE: begin
          if (!bus.in_ring.last) begin
            state_d = S_WORM;
            cls_d   = hdr_cls;
            tgt_d   = hdr_tgt;
          end
        end
        S_WORM: begin
          if (bus.in_ring.last) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    rv_d    = rv_q;
    rdata_d = rdata_q;
    rlast_d = rlast_q;
    rcls_d  = rcls_q;
    rtgt_d  = rtgt_q;
    if (accept) begin
      rv_d    = 1'b1;
      rdata_d = bus.in_ring.data;
      rlast_d = bus.in_ring.last;
      rcls_d  = cur_cls;
      rtgt_d  = cur_tgt;
    end else if (sel_ready) begin
      rv_d = 1'b0;
    end
  end

  always_comb begin
    cnt_local_d = cnt_local_q;
    cnt_ext_d   = cnt_ext_q;
    cnt_ring_d  = cnt_ring_q;
    if (accept && hdr) begin
      unique case (1'b1)
        (hdr_cls == C_LOCAL): cnt_local_d = cnt_local_q + 16'd1;
        (hdr_cls == C_EXT):   cnt_ext_d   = cnt_ext_q + 16'd1;
        default:              cnt_ring_d  = cnt_ring_q + 16'd1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rv_q        <= 1'b0;
      cnt_local_q <= '0;
      cnt_ext_q   <= '0;
      cnt_ring_q  <= '0;
    end else begin
      state_q     <= state_d;
      rv_q        <= rv_d;
      cnt_local_q <= cnt_local_d;
      cnt_ext_q   <= cnt_ext_d;
      cnt_ring_q  <= cnt_ring_d;
    end
  end

  // Route and payload need no reset; they are qualified by state/valid
  always_ff @(posedge clk) begin
    cls_q   <= cls_d;
    tgt_q   <= tgt_d;
    rdata_q <= rdata_d;
    rlast_q <= rlast_d;
    rcls_q  <= rcls_d;
    rtgt_q  <= rtgt_d;
  end

  assign cnt_local = cnt_local_q;
  assign cnt_ext   = cnt_ext_q;
  assign cnt_ring  = cnt_ring_q;

endmodule

// File: tb/tb_ring_router_gateway_demux_n.sv
// Scoreboard bench for ring_router_gateway_demux_n (defaults, REG_OUT=1).
// Port codes: 0..1 local endpoints, 8 ext, 9 ring.
module tb_ring_router_gateway_demux_n;
  import ring_router_gateway_demux_n_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] id;
  logic [15:0] cnt_local, cnt_ext, cnt_ring;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int          port;
    logic [15:0] data;
    logic        last;
    int          cyc;
  } exp_t;

  exp_t q[$];

  ring_router_gateway_demux_n_if #(.NUM_LOCAL(2)) bus ();

  ring_router_gateway_demux_n #(
    .SUBNET_BITS (6),
    .LOCAL_SUBNET(0),
    .NUM_LOCAL   (2),
    .REG_OUT     (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .id       (id),
    .bus      (bus),
    .cnt_local(cnt_local),
    .cnt_ext  (cnt_ext),
    .cnt_ring (cnt_ring)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops an expectation for every transfer on any output
  always @(negedge clk) begin
    int          nv;
    int          port;
    logic [15:0] d;
    logic        l;
    logic        rdy;
    exp_t        e;
    nv   = 0;
    port = -1;
    d    = '0;
    l    = 1'b0;
    rdy  = 1'b0;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (bus.out_local[i].valid) begin
          nv++;
          port = i;
          d    = bus.out_local[i].data;
          l    = bus.out_local[i].last;
          rdy  = bus.out_local_ready[i];
        end
      end
      if (bus.out_ext.valid) begin
        nv++;
        port = 8;
        d    = bus.out_ext.data;
        l    = bus.out_ext.last;
        rdy  = bus.out_ext_ready;
      end
      if (bus.out_ring.valid) begin
        nv++;
        port = 9;
        d    = bus.out_ring.data;
        l    = bus.out_ring.last;
        rdy  = bus.out_ring_ready;
      end
      if (nv > 1) begin
        chk("one_valid", nv, 1);
      end else if (nv == 1 && rdy) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_flit port=%0d data=%0h", port, d);
        end else begin
          e = q.pop_front();
          chk("port", port, e.port);
          chk("data", d, e.data);
          chk("last", l, e.last);
          if (e.cyc >= 0) chk("latency", cyc, e.cyc);
        end
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic l, input int port,
                      input bit lat, output int acc);
    exp_t e;
    bus.in_ring.data  = d;
    bus.in_ring.last  = l;
    bus.in_ring.valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.in_ring_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout data=%0h", d);
    end else begin
      e.port = port;
      e.data = d;
      e.last = l;
      e.cyc  = lat ? acc + 1 : -1;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_ring.valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] l,
                         input logic [15:0] e, input logic [15:0] r);
    chk({tag, "_cnt_local"}, cnt_local, l);
    chk({tag, "_cnt_ext"}, cnt_ext, e);
    chk({tag, "_cnt_ring"}, cnt_ring, r);
  endtask

  initial begin
    int a1, a2, a3, a4;
    rst                 = 1'b1;
    id                  = 16'h0004;
    bus.in_ring.data    = 16'h0005;
    bus.in_ring.last    = 1'b0;
    bus.in_ring.valid   = 1'b1;
    bus.out_local_ready = 2'b11;
    bus.out_ext_ready   = 1'b1;
    bus.out_ring_ready  = 1'b1;

    // Reset state: nothing accepted or presented while rst is high
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ring_ready, 0);
    chk("rst_valids", {bus.out_local[1].valid, bus.out_local[0].valid,
                       bus.out_ext.valid, bus.out_ring.valid}, 0);
    @(posedge clk);
    #1;
    chk_cnt("rst", 0, 0, 0);
    bus.in_ring.valid = 1'b0;
    rst = 1'b0;

    // Local hit: 0x0005 - 0x0004 = 1 -> out_local[1]
    send(16'h0005, 1'b0, 1, 1'b1, a1);
    send(16'h1111, 1'b0, 1, 1'b1, a1);
    send(16'h2222, 1'b1, 1, 1'b1, a1);
    drain();
    chk_cnt("local", 1, 0, 0);

    // Ext (subnet 1) and ring (subnet 0, not local)
    send(16'h0400, 1'b1, 8, 1'b1, a1);
    send(16'h0009, 1'b1, 9, 1'b1, a1);
    drain();
    chk_cnt("split", 1, 1, 1);

    // Worm hold with backpressure on the held body flit 0x0400
    send(16'h0004, 1'b0, 0, 1'b1, a1);
    send(16'h0400, 1'b0, 0, 1'b0, a2);
    bus.out_local_ready[0] = 1'b0;
    bus.in_ring.data  = 16'h3333;
    bus.in_ring.last  = 1'b0;
    bus.in_ring.valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", bus.out_local[0].valid, 1);
      chk("hold_data", bus.out_local[0].data, 16'h0400);
      chk("hold_last", bus.out_local[0].last, 0);
      chk("hold_in_ready", bus.in_ring_ready, 0);
    end
    @(posedge clk);
    #1;
    bus.out_local_ready[0] = 1'b1;
    send(16'h3333, 1'b0, 0, 1'b1, a3);
    send(16'h4444, 1'b1, 0, 1'b1, a4);
    chk("full_rate", a4, a3 + 1);
    drain();
    chk_cnt("worm", 2, 1, 1);

    // Single-flit ring header then local packet, back to back
    send(16'h0009, 1'b1, 9, 1'b1, a1);
    send(16'h0005, 1'b0, 1, 1'b1, a2);
    send(16'hAAAA, 1'b1, 1, 1'b1, a3);
    chk("no_bubble_hdr", a2, a1 + 1);
    chk("no_bubble_body", a3, a2 + 1);
    drain();
    chk_cnt("b2b", 3, 1, 2);

    // id change mid-worm keeps the latched route
    send(16'h0005, 1'b0, 1, 1'b1, a1);
    id = 16'h0400;
    send(16'h0000, 1'b1, 1, 1'b1, a1);
    id = 16'h0004;
    drain();
    chk_cnt("id_chg", 4, 1, 2);

    // Reset mid-worm, then a wrapped-offset header
    send(16'h0004, 1'b0, 0, 1'b1, a1);
    send(16'h5555, 1'b0, 0, 1'b1, a1);
    drain();
    rst = 1'b1;
    bus.in_ring.data  = 16'h6666;
    bus.in_ring.last  = 1'b0;
    bus.in_ring.valid = 1'b1;
    @(negedge clk);
    chk("rst2_in_ready", bus.in_ring_ready, 0);
    chk("rst2_valids", {bus.out_local[1].valid, bus.out_local[0].valid,
                        bus.out_ext.valid, bus.out_ring.valid}, 0);
    @(posedge clk);
    #1;
    chk_cnt("rst2", 0, 0, 0);
    bus.in_ring.valid = 1'b0;
    rst = 1'b0;
    id  = 16'hFFFE;
    send(16'hFFFF, 1'b1, 1, 1'b1, a1);
    drain();
    chk_cnt("wrap_hdr", 1, 0, 0);

    // Ring counter wrap: 0x0009 - 0xFFFE = 0x000B, subnet 0 -> ring
    for (int k = 0; k < 65535; k++) begin
      send(16'h0009, 1'b1, 9, 1'b0, a1);
    end
    drain();
    chk("cnt_ring_max", cnt_ring, 16'hFFFF);
    send(16'h0009, 1'b1, 9, 1'b0, a1);
    drain();
    chk("cnt_ring_wrap", cnt_ring, 16'h0000);
    chk("cnt_local_final", cnt_local, 16'h0001);

    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ring_router_gateway_demux_n.md
RING_ROUTER_GATEWAY_DEMUX_N -- requirements
Module: ring_router_gateway_demux_n

Interface
REQ-001 Parameter SUBNET_BITS, default 6: number of destination MSBs, data[15:16-SUBNET_BITS], that form the subnet field.
REQ-002 Parameter LOCAL_SUBNET, default 0: subnet value of this gateway's subnet.
REQ-003 Parameter NUM_LOCAL, default 2, range 1..8: number of local endpoints, addressed id .. id+NUM_LOCAL-1.
REQ-004 Parameter REG_OUT, default 1: 1 = registered output stage; 0 = combinational pass-through.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 id  input  16  base endpoint ID of local endpoint 0; quasi-static.
REQ-008 in_ring  input  dii_flit  incoming ring flit (data[15:0], last, valid).
REQ-009 in_ring_ready  output  1  flit accepted when in_ring.valid & in_ring_ready.
REQ-010 out_local  output  dii_flit[NUM_LOCAL]  one flit port per local endpoint.
REQ-011 out_local_ready  input  NUM_LOCAL  per-endpoint ready.
REQ-012 out_ext  output  dii_flit  flits leaving the subnet.
REQ-013 out_ext_ready  input  1  ready for out_ext.
REQ-014 out_ring  output  dii_flit  flits forwarded along the ring.
REQ-015 out_ring_ready  input  1  ready for out_ring.
REQ-016 cnt_local, cnt_ext, cnt_ring  output  16 each  packets routed per class.

Function
REQ-017 A packet is a run of flits ending with last=1; the first flit is the header, and its data[15:0] is the destination ID.
REQ-018 Header classification:
- offset = data[15:0] - id, computed as 16-bit unsigned with wrap.
- local when offset < NUM_LOCAL, target endpoint = offset.
- otherwise ext when data[15:16-SUBNET_BITS] != LOCAL_SUBNET.
- otherwise ring.
- priority is local > ext > ring.
REQ-019 Worm FSM has two states, IDLE and WORM.
- IDLE -> WORM on header acceptance with last=0; the class and target index are latched at that point.
- WORM -> IDLE on acceptance of a flit with last=1.
- A header with last=1 is a single-flit packet and leaves the FSM in IDLE.
REQ-020 In WORM, every flit follows the latched route regardless of its data.
REQ-021 Data and last are copied unmodified to the selected output; all non-selected outputs hold valid=0.
REQ-022 REG_OUT=0:
- Selected output valid = in_ring.valid, latency 0 cycles.
- in_ring_ready = ready of the selected output.
REQ-023 REG_OUT=1: one output register holds the flit and its route.
- in_ring_ready = !reg_valid | sel_ready, giving full throughput of 1 flit/cycle.
- Latency is exactly 1 cycle from acceptance to output valid.
- When reg_valid=0, the register is empty; when reg_valid=1 and sel_ready=0, it holds stable (data, last, route) until accepted.
REQ-024 The accepting output's ready is never combinationally dependent on a different output's ready.
REQ-025 Each counter increments by 1 at header acceptance for its class, wraps from 0xFFFF to 0, and ignores non-header flits.
REQ-026 Back-to-back packets: a header immediately following a last flit is classified in the same cycle it is presented, with no bubble.
REQ-027 A change of id while in WORM does not affect the packet in flight.

Reset
REQ-028 On rst=1 at a clock edge, the block enters the following state:
- FSM = IDLE.
- reg_valid = 0.
- Latched route = don't-care.
- cnt_* = 0.
REQ-029 During reset, all output valids are 0 and in_ring_ready is 0 when REG_OUT=1.
REQ-030 Reset mid-packet discards the worm; the first flit accepted after reset is treated as a header.

Verification
REQ-031 Bench coverage (defaults unless stated):
- Local hit: id=0x0004, header 0x0005, 3-flit packet -> all flits on out_local[1] only, cnt_local=1, 1-cycle latency.
- Ext/ring split, id=0x0004: header 0x0400 (subnet 1) -> out_ext, cnt_ext=1; header 0x0009 -> out_ring, cnt_ring=1.
- Worm hold: 4-flit packet to 0x0004 whose body flit data=0x0400 -> all flits on out_local[0]; nothing on out_ext.
- Backpressure, REG_OUT=1: out_local_ready=0 for 5 cycles mid-packet -> output register stable, in_ring_ready=0, no flit lost or duplicated; full rate after release.
- Single-flit and back-to-back: header last=1 to ring, then header to local next cycle -> FSM stays IDLE, routes are correct, no bubble.
- Reset mid-worm and wrap: assert rst after flit 2 of 4, then send header 0xFFFF with id=0xFFFE -> cnt_*=0 after reset, header routed to out_local[1]; a further 65536 ring packets return cnt_ring to 0.
